sipo_frame_ctrl: RTL and testbench

Framing and hand-off controller for a serial-in/parallel-out shift path. It qualifies serial bits with a strobe and detects frame start. It counts WIDTH bits into an internal shift register, then moves the completed word into a double-buffered output register with a valid/ready handshake. It sits between a bit-level serial front end and any word-level consumer, and reports overrun and framing errors.

---
 rtl/sipo_pkg.sv | 19 +
 rtl/sipo_shift_reg.sv | 51 +++++
 rtl/sipo_frame_ctrl.sv | 178 +++++++++++++++++
 tb/tb_sipo_frame_ctrl.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/sipo_pkg.sv
// Shared definitions for the serial-in/parallel-out framing controller.
// Holds the controller state encoding, default geometry constants and a
// helper that sizes counters able to hold the values 0..n.
package sipo_pkg;

   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_SHIFT = 1'b1
   } state_e;

   localparam int DEF_WIDTH   = 4;
   localparam int DEF_TIMEOUT = 16;

   // Bits needed to represent 0..n (at least one bit).
   function automatic int cnt_width(input int n);
      return (n < 1) ? 1 : $clog2(n + 1);
   endfunction

endpackage

// File: rtl/sipo_shift_reg.sv
// WIDTH-bit serial-in shift register, first bit migrates towards the MSB.
// Ports:
//   clk, rst    clock / asynchronous active-high reset
//   shift_en_i  take din_i this cycle
//   restart_i   with shift_en_i: discard contents, din_i becomes the only bit
//   din_i       serial data bit
//   q_o         current register contents
//   nxt_o       value the register takes at the next clock edge
module sipo_shift_reg #(
   parameter int WIDTH = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             shift_en_i,
   input  logic             restart_i,
   input  logic             din_i,
   output logic [WIDTH-1:0] q_o,
   output logic [WIDTH-1:0] nxt_o
);

   logic [WIDTH-1:0] sreg_q;
   logic [WIDTH-1:0] sreg_d;
   logic [WIDTH-1:0] shifted;

   generate
      if (WIDTH == 1) begin : g_one
         assign shifted = din_i;
      end else begin : g_many
         assign shifted = {sreg_q[WIDTH-2:0], din_i};
      end
   endgenerate

   always_comb begin
      sreg_d = sreg_q;
      if (shift_en_i) begin
         sreg_d = restart_i ? WIDTH'(din_i) : shifted;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sreg_q <= '0;
      end else begin
         sreg_q <= sreg_d;
      end
   end

   assign q_o   = sreg_q;
   assign nxt_o = sreg_d;

endmodule

// File: rtl/sipo_frame_ctrl.sv
// Framing and hand-off controller for a serial-in/parallel-out path.
// Strobed serial bits are collected into a WIDTH-bit word (first bit ends at
// the MSB) and handed to a single-entry output buffer with valid/ready.
// Ports:
//   clk, rst     clock / asynchronous active-high reset
//   ser_in       serial data bit, sampled when ser_vld=1
//   ser_vld      bit strobe
//   frame_start  current strobed bit is bit 1 of a frame
//   out_rdy      consumer ready
//   clr_ovr      clears the sticky overrun flag
//   par_out      buffered word
//   par_vld      par_out holds an untransferred word
//   overrun      sticky: a completed word was dropped
//   frame_err    one-cycle pulse after a restart or a timeout abort
//   busy         frame in progress (SHIFT state)
//   bit_cnt      bits captured in the current frame
//
// Handshake: a word moves to the consumer on any cycle where par_vld and
// out_rdy are both high; while par_vld=1 and no transfer happens, par_out
// holds its value and par_vld stays high.
module sipo_frame_ctrl
   import sipo_pkg::*;
#(
   parameter int WIDTH   = DEF_WIDTH,
   parameter int TIMEOUT = DEF_TIMEOUT
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          ser_in,
   input  logic                          ser_vld,
   input  logic                          frame_start,
   input  logic                          out_rdy,
   input  logic                          clr_ovr,
   output logic [WIDTH-1:0]              par_out,
   output logic                          par_vld,
   output logic                          overrun,
   output logic                          frame_err,
   output logic                          busy,
   output logic [cnt_width(WIDTH)-1:0]   bit_cnt
);

   localparam int CW = cnt_width(WIDTH);
   localparam int IW = cnt_width(TIMEOUT);
   localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);
   localparam logic [IW-1:0] IDLE_LAST = IW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

   state_e           state_q, state_d;
   logic [CW-1:0]    bit_cnt_q, bit_cnt_d;
   logic [IW-1:0]    idle_q, idle_d;
   logic [WIDTH-1:0] par_out_q, par_out_d;
   logic             par_vld_q, par_vld_d;
   logic             ovr_q, ovr_d;
   logic             ferr_q, ferr_d;

   logic             shift_en;
   logic             restart;
   logic             complete;
   logic             abort;
   logic             xfer;
   logic [WIDTH-1:0] sreg;
   logic [WIDTH-1:0] word;

   sipo_shift_reg #(.WIDTH(WIDTH)) u_sreg (
      .clk        (clk),
      .rst        (rst),
      .shift_en_i (shift_en),
      .restart_i  (restart),
      .din_i      (ser_in),
      .q_o        (sreg),
      .nxt_o      (word)
   );

   // Frame FSM and counters
   always_comb begin
      state_d   = state_q;
      bit_cnt_d = bit_cnt_q;
      idle_d    = idle_q;
      shift_en  = 1'b0;
      restart   = 1'b0;
      complete  = 1'b0;
      abort     = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (ser_vld && frame_start) begin
               shift_en = 1'b1;
               restart  = 1'b1;
               idle_d   = '0;
               if (WIDTH == 1) begin
                  complete = 1'b1;
               end else begin
                  state_d   = ST_SHIFT;
                  bit_cnt_d = CW'(1);
               end
            end
         end
         ST_SHIFT: begin
            if (ser_vld) begin
               shift_en = 1'b1;
               idle_d   = '0;
               if (frame_start) begin
                  // Restart: partial frame dropped, this bit is bit 1.
                  restart   = 1'b1;
                  abort     = 1'b1;
                  bit_cnt_d = CW'(1);
               end else if (bit_cnt_q == LAST_BIT) begin
                  complete  = 1'b1;
                  state_d   = ST_IDLE;
                  bit_cnt_d = '0;
               end else begin
                  bit_cnt_d = bit_cnt_q + CW'(1);
               end
            end else if (TIMEOUT > 0) begin
               if (idle_q == IDLE_LAST) begin
                  abort     = 1'b1;
                  state_d   = ST_IDLE;
                  bit_cnt_d = '0;
                  idle_d    = '0;
               end else begin
                  idle_d = idle_q + IW'(1);
               end
            end
         end
         default: begin
            state_d   = ST_IDLE;
            bit_cnt_d = '0;
            idle_d    = '0;
         end
      endcase
   end

   // Output buffer: a completed word (taken from the shift register's next
   // value, so it lands in the same edge as the completing bit) is accepted
   // if the buffer is empty or is being emptied this cycle.
   assign xfer = par_vld_q && out_rdy;

   always_comb begin
      par_out_d = par_out_q;
      par_vld_d = par_vld_q && !xfer;
      ovr_d     = ovr_q && !clr_ovr;
      ferr_d    = abort;
      if (complete) begin
         if (!par_vld_q || xfer) begin
            par_out_d = word;
            par_vld_d = 1'b1;
         end else begin
            ovr_d = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= ST_IDLE;
         bit_cnt_q <= '0;
         idle_q    <= '0;
         par_out_q <= '0;
         par_vld_q <= 1'b0;
         ovr_q     <= 1'b0;
         ferr_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         bit_cnt_q <= bit_cnt_d;
         idle_q    <= idle_d;
         par_out_q <= par_out_d;
         par_vld_q <= par_vld_d;
         ovr_q     <= ovr_d;
         ferr_q    <= ferr_d;
      end
   end

   assign par_out   = par_out_q;
   assign par_vld   = par_vld_q;
   assign overrun   = ovr_q;
   assign frame_err = ferr_q;
   assign busy      = (state_q == ST_SHIFT);
   assign bit_cnt   = bit_cnt_q;

endmodule

// File: tb/tb_sipo_frame_ctrl.sv
module tb_sipo_frame_ctrl;

   localparam int W  = 4;
   localparam int TO = 16;
   localparam int CW = $clog2(W + 1);

   logic          clk;
   logic          rst;
   logic          ser_in, ser_vld, frame_start, out_rdy, clr_ovr;
   logic [W-1:0]  par_out;
   logic          par_vld, overrun, frame_err, busy;
   logic [CW-1:0] bit_cnt;

   int n_checks = 0;
   int n_fail   = 0;

   // Reference model state: bits of the open frame, silence run, buffer.
   bit           m_bits[$];
   bit           m_in_frame;
   int           m_silent;
   logic [W-1:0] m_pout;
   bit           m_vld, m_ovr, m_err;
   logic [W-1:0] exp_q[$];

   sipo_frame_ctrl #(.WIDTH(W), .TIMEOUT(TO)) dut (
      .clk         (clk),
      .rst         (rst),
      .ser_in      (ser_in),
      .ser_vld     (ser_vld),
      .frame_start (frame_start),
      .out_rdy     (out_rdy),
      .clr_ovr     (clr_ovr),
      .par_out     (par_out),
      .par_vld     (par_vld),
      .overrun     (overrun),
      .frame_err   (frame_err),
      .busy        (busy),
      .bit_cnt     (bit_cnt)
   );

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_bits.delete();
      m_in_frame = 1'b0;
      m_silent   = 0;
      m_pout     = '0;
      m_vld      = 1'b0;
      m_ovr      = 1'b0;
      m_err      = 1'b0;
      exp_q.delete();
   endtask

   // One clock edge of the specified behaviour, from the current inputs.
   task automatic model_step();
      bit           xfer, done, err, set_ovr;
      logic [W-1:0] w;
      xfer = m_vld && out_rdy;
      done = 1'b0;
      err  = 1'b0;
      w    = '0;
      if (ser_vld) begin
         if (frame_start) begin
            if (m_in_frame) err = 1'b1;
            m_bits.delete();
            m_bits.push_back(ser_in);
            m_in_frame = 1'b1;
            m_silent   = 0;
         end else if (m_in_frame) begin
            m_bits.push_back(ser_in);
            m_silent = 0;
         end
         if (m_in_frame && m_bits.size() == W) begin
            for (int i = 0; i < W; i++) w[W-1-i] = m_bits[i];
            done = 1'b1;
            m_bits.delete();
            m_in_frame = 1'b0;
         end
      end else if (m_in_frame) begin
         m_silent++;
         if (m_silent == TO) begin
            err = 1'b1;
            m_bits.delete();
            m_in_frame = 1'b0;
            m_silent   = 0;
         end
      end
      set_ovr = done && m_vld && !xfer;
      if (xfer) m_vld = 1'b0;
      if (done && !m_vld) begin
         m_pout = w;
         m_vld  = 1'b1;
         exp_q.push_back(w);
      end
      if (set_ovr) m_ovr = 1'b1;
      else if (clr_ovr) m_ovr = 1'b0;
      m_err = err;
   endtask

   task automatic check_all();
      check("par_out", par_out, m_pout);
      check("par_vld", par_vld, m_vld);
      check("overrun", overrun, m_ovr);
      check("frame_err", frame_err, m_err);
      check("busy", busy, m_in_frame);
      check("bit_cnt", bit_cnt, m_bits.size());
   endtask

   // driver: one cycle with the inputs currently applied
   task automatic cycle();
      logic [W-1:0] e;
      if (m_vld && out_rdy) begin
         if (exp_q.size() == 0) begin
            check("xfer_queue_empty", 1, 0);
         end else begin
            e = exp_q.pop_front();
            check("xfer_word", par_out, e);
         end
      end
      @(posedge clk);
      model_step();
      #1;
      check_all();
   endtask

   task automatic idle(input int n, input bit rdy);
      ser_vld = 1'b0; frame_start = 1'b0; out_rdy = rdy; clr_ovr = 1'b0;
      repeat (n) cycle();
   endtask

   task automatic send_frame(input logic [W-1:0] w, input int gap,
                             input bit rdy, input bit rdy_last);
      for (int i = 0; i < W; i++) begin
         ser_vld = 1'b1; ser_in = w[W-1-i]; frame_start = (i == 0);
         out_rdy = (i == W - 1) ? rdy_last : rdy; clr_ovr = 1'b0;
         cycle();
         if (i != W - 1 && gap > 0) idle(gap, rdy);
      end
      ser_vld = 1'b0; frame_start = 1'b0;
   endtask

   task automatic send_bit(input bit b, input bit fs, input bit rdy);
      ser_vld = 1'b1; ser_in = b; frame_start = fs; out_rdy = rdy; clr_ovr = 1'b0;
      cycle();
      ser_vld = 1'b0; frame_start = 1'b0;
   endtask

   task automatic check_zero(input string tag);
      check({tag, "_par_out"}, par_out, 0);
      check({tag, "_par_vld"}, par_vld, 0);
      check({tag, "_overrun"}, overrun, 0);
      check({tag, "_frame_err"}, frame_err, 0);
      check({tag, "_busy"}, busy, 0);
      check({tag, "_bit_cnt"}, bit_cnt, 0);
   endtask

   task automatic apply_reset();
      rst = 1'b1;
      #1;
      check_zero("reset");
      model_reset();
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
   endtask

   initial begin
      ser_in = 1'b0; ser_vld = 1'b0; frame_start = 1'b0;
      out_rdy = 1'b0; clr_ovr = 1'b0; rst = 1'b0;
      model_reset();
      #2;
      apply_reset();

      // basic frame 1011
      send_frame(4'b1011, 0, 1'b1, 1'b1);
      check("t1_word", par_out, 4'b1011);
      check("t1_vld", par_vld, 1);
      check("t1_ovr", overrun, 0);
      idle(1, 1'b1);
      check("t1_vld_drop", par_vld, 0);
      idle(2, 1'b1);

      // same frame with 3-cycle gaps
      send_frame(4'b1011, 3, 1'b1, 1'b1);
      check("t2_word", par_out, 4'b1011);
      check("t2_busy_done", busy, 0);
      idle(2, 1'b1);

      // overrun
      send_frame(4'b1100, 0, 1'b0, 1'b0);
      send_frame(4'b0011, 0, 1'b0, 1'b0);
      check("t3_word_held", par_out, 4'b1100);
      check("t3_ovr_set", overrun, 1);
      clr_ovr = 1'b1; cycle(); clr_ovr = 1'b0;
      check("t3_ovr_clr", overrun, 0);
      idle(1, 1'b1);
      check("t3_vld_after_xfer", par_vld, 0);

      // completion on the same cycle as a transfer
      send_frame(4'b1010, 0, 1'b0, 1'b0);
      send_frame(4'b0101, 0, 1'b0, 1'b1);
      check("t4_word", par_out, 4'b0101);
      check("t4_vld", par_vld, 1);
      check("t4_ovr", overrun, 0);
      idle(2, 1'b1);

      // restart mid-frame
      send_bit(1'b1, 1'b1, 1'b1);
      send_bit(1'b1, 1'b0, 1'b1);
      send_bit(1'b0, 1'b1, 1'b1);
      check("t5_ferr", frame_err, 1);
      check("t5_cnt", bit_cnt, 1);
      send_bit(1'b1, 1'b0, 1'b1);
      check("t5_ferr_pulse", frame_err, 0);
      send_bit(1'b1, 1'b0, 1'b1);
      send_bit(1'b0, 1'b0, 1'b1);
      check("t5_word", par_out, 4'b0110);
      idle(2, 1'b1);

      // timeout
      send_bit(1'b1, 1'b1, 1'b1);
      send_bit(1'b0, 1'b0, 1'b1);
      idle(TO - 1, 1'b1);
      check("t6_busy_before", busy, 1);
      check("t6_ferr_before", frame_err, 0);
      idle(1, 1'b1);
      check("t6_ferr", frame_err, 1);
      check("t6_busy", busy, 0);
      check("t6_cnt", bit_cnt, 0);
      check("t6_vld", par_vld, 0);
      idle(1, 1'b1);

      // reset mid-frame with a pending word
      send_frame(4'b1111, 0, 1'b0, 1'b0);
      send_bit(1'b1, 1'b1, 1'b0);
      send_bit(1'b0, 1'b0, 1'b0);
      apply_reset();
      idle(2, 1'b1);

      // randomized traffic with varying strobe density
      for (int blk = 0; blk < 30; blk++) begin
         int dens;
         case ($urandom_range(2, 0))
            0:       dens = 10;
            1:       dens = 50;
            default: dens = 90;
         endcase
         for (int c = 0; c < 100; c++) begin
            ser_vld     = ($urandom_range(99, 0) < dens);
            ser_in      = $urandom_range(1, 0);
            frame_start = ($urandom_range(99, 0) < 15);
            out_rdy     = ($urandom_range(1, 0) == 1);
            clr_ovr     = ($urandom_range(99, 0) < 5);
            cycle();
         end
      end
      idle(2, 1'b1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
